instr_queue: RTL and testbench

Instruction queue between the fetch stage and the decode stage of the RISC-V core. It buffers up to DEPTH fetched instruction/PC pairs behind a valid/ready handshake, so fetch keeps running while decode stalls. It discards all buffered entries on a branch/jump flush. It also flags unsupported encodings before decode.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/instr_predecode.sv | 20 ++
 rtl/instr_queue.sv | 96 +++++++++
 tb/tb_instr_queue.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the front end: datapath width, the canonical
// NOP encoding and the 32-bit opcode-field check.
package riscv_pkg;

    localparam int          XLEN = 32;
    localparam logic [31:0] NOP  = 32'h0000_0013;   // addi x0, x0, 0

    // Only full 32-bit encodings (low two bits 2'b11) are supported; anything
    // else is a compressed or reserved encoding.
    function automatic logic is_illegal_op(input logic [1:0] op);
        return (op != 2'b11);
    endfunction

endpackage

// File: rtl/instr_predecode.sv
// Combinational predecode of a fetched instruction word. Today it only flags
// unsupported encodings; further predecode bits for decode belong here too.
module instr_predecode #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN-1:0] instruction,
    output logic            illegal
);
    import riscv_pkg::*;

    // Upper bits are reserved for future predecode outputs.
    logic unused_hi;

    // Flag encodings whose low two bits are not 2'b11.
    always_comb begin
        illegal   = is_illegal_op(instruction[1:0]);
        unused_hi = ^instruction[XLEN-1:2];
    end

endmodule

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry circular buffer of
// {pc, instruction, illegal} with valid/ready on both sides and a flush that
// drops everything buffered. DEPTH must be a power of two and at least 2 so
// the pointers wrap naturally.
module instr_queue #(
    parameter int              XLEN  = riscv_pkg::XLEN,
    parameter int              DEPTH = 4,
    parameter logic [XLEN-1:0] NOP   = riscv_pkg::NOP
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_instruction,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_instruction,
    output logic                       out_illegal,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int             PW   = $clog2(DEPTH);
    localparam int             CW   = $clog2(DEPTH+1);
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic            ill_mem   [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          in_illegal;

    instr_predecode #(
        .XLEN (XLEN)
    ) u_predecode (
        .instruction (in_instruction),
        .illegal     (in_illegal)
    );

    // Handshake qualifiers; in_ready looks only at occupancy and flush so
    // there is no path from out_ready back to fetch.
    always_comb begin
        in_ready  = reset && !flush && (count != FULL);
        out_valid = (count != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready && !flush;
    end

    // Pointer and occupancy update; flush overrides any push/pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only observed while count says they are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instruction;
            ill_mem[wr_ptr]   <= in_illegal;
        end
    end

    // Head presentation; an empty queue shows a harmless NOP at PC 0.
    always_comb begin
        out_pc          = '0;
        out_instruction = NOP;
        out_illegal     = 1'b0;
        if (out_valid) begin
            out_pc          = pc_mem[rd_ptr];
            out_instruction = instr_mem[rd_ptr];
            out_illegal     = ill_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
module tb_instr_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] in_pc = '0;
    logic [XLEN-1:0] in_instruction = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instruction;
    logic            out_illegal;
    logic            flush = 1'b0;
    logic [2:0]      count;

    int total = 0;
    int bad   = 0;

    instr_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP(NOP_W)) dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pc           (in_pc),
        .in_instruction  (in_instruction),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .out_illegal     (out_illegal),
        .flush           (flush),
        .count           (count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[23:0], 8'h13};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b want=0", in_ready); end
        total++; if (out_instruction !== 32'h0000_0013) begin bad++; $display("FAIL rst_out_instr got=%h want=00000013", out_instruction); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL rst_out_pc got=%h want=0", out_pc); end
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got=%0b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_release_out_valid got=%0b want=0", out_valid); end
        tick();
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc = 32'(i * 4);
            in_instruction = instr_of(32'(i * 4));
            tick();
            total++; if (count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, count, i + 1); end
            total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL fill_head[%0d] got=%h want=0", i, out_pc); end
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%0b want=0", in_ready); end
        in_pc = 32'h100;
        in_instruction = instr_of(32'h100);
        tick();
        in_valid = 1'b0;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_refused_count got=%0d want=4", count); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL fill_refused_head got=%h want=0", out_pc); end
        total++; if (out_instruction !== 32'h0000_0013) begin bad++; $display("FAIL fill_head_instr got=%h want=00000013", out_instruction); end
    endtask

    task automatic test_drain_wrap();
        logic [31:0] exp_pc [6];
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            total++; if (out_pc !== exp_pc[k]) begin bad++; $display("FAIL drain_pc[%0d] got=%h want=%h", k, out_pc, exp_pc[k]); end
            tick();
        end
        out_ready = 1'b0;
        total++; if (count !== 3'd2) begin bad++; $display("FAIL drain_mid_count got=%0d want=2", count); end
        for (int k = 4; k < 6; k++) begin
            in_valid = 1'b1;
            in_pc = exp_pc[k];
            in_instruction = instr_of(exp_pc[k]);
            tick();
        end
        in_valid = 1'b0;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL wrap_full_count got=%0d want=4", count); end
        out_ready = 1'b1;
        for (int k = 2; k < 6; k++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid[%0d] got=%0b want=1", k, out_valid); end
            total++; if (out_pc !== exp_pc[k]) begin bad++; $display("FAIL wrap_pc[%0d] got=%h want=%h", k, out_pc, exp_pc[k]); end
            total++; if (out_instruction !== instr_of(exp_pc[k])) begin bad++; $display("FAIL wrap_instr[%0d] got=%h want=%h", k, out_instruction, instr_of(exp_pc[k])); end
            tick();
        end
        out_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL wrap_end_count got=%0d want=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_end_valid got=%0b want=0", out_valid); end
        total++; if (out_instruction !== 32'h0000_0013) begin bad++; $display("FAIL wrap_end_instr got=%h want=00000013", out_instruction); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] head;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_pc = 32'h20 + 32'(i * 4);
            in_instruction = instr_of(in_pc);
            tick();
        end
        total++; if (count !== 3'd2) begin bad++; $display("FAIL b2b_pre_count got=%0d want=2", count); end
        head = 32'h20;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_pc = 32'h28 + 32'(k * 4);
            in_instruction = instr_of(in_pc);
            out_ready = 1'b1;
            #1;
            total++; if (out_pc !== head) begin bad++; $display("FAIL b2b_pc[%0d] got=%h want=%h", k, out_pc, head); end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d] got=%0b want=1", k, in_ready); end
            tick();
            head = head + 32'h4;
            total++; if (count !== 3'd2) begin bad++; $display("FAIL b2b_count[%0d] got=%0d want=2", k, count); end
        end
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            total++; if (out_pc !== head) begin bad++; $display("FAIL b2b_drain_pc[%0d] got=%h want=%h", k, out_pc, head); end
            tick();
            head = head + 32'h4;
        end
        out_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL b2b_end_count got=%0d want=0", count); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_pc = 32'h40 + 32'(i * 4);
            in_instruction = instr_of(in_pc);
            tick();
        end
        total++; if (count !== 3'd3) begin bad++; $display("FAIL flush_pre_count got=%0d want=3", count); end
        flush = 1'b1;
        in_valid = 1'b1;
        in_pc = 32'h4C;
        in_instruction = instr_of(32'h4C);
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%0b want=0", in_ready); end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_after_in_ready got=%0b want=1", in_ready); end
        tick();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_push_dropped got=%0d want=0", count); end
        in_valid = 1'b1;
        in_pc = 32'h50;
        in_instruction = instr_of(32'h50);
        tick();
        in_valid = 1'b0;
        total++; if (out_pc !== 32'h50) begin bad++; $display("FAIL flush_next_pc got=%h want=00000050", out_pc); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL flush_next_count got=%0d want=1", count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_end_count got=%0d want=0", count); end
    endtask

    task automatic test_illegal_async();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_pc = 32'h60;
        in_instruction = 32'h0000_0001;
        tick();
        in_pc = 32'h64;
        in_instruction = instr_of(32'h64);
        tick();
        in_valid = 1'b0;
        total++; if (out_illegal !== 1'b1) begin bad++; $display("FAIL ill_flag got=%0b want=1", out_illegal); end
        total++; if (out_instruction !== 32'h0000_0001) begin bad++; $display("FAIL ill_instr got=%h want=00000001", out_instruction); end
        total++; if (out_pc !== 32'h60) begin bad++; $display("FAIL ill_pc got=%h want=00000060", out_pc); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (out_illegal !== 1'b0) begin bad++; $display("FAIL legal_flag got=%0b want=0", out_illegal); end
        total++; if (out_pc !== 32'h64) begin bad++; $display("FAIL legal_pc got=%h want=00000064", out_pc); end
        #2 reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_out_valid got=%0b want=0", out_valid); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL async_count got=%0d want=0", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL async_in_ready got=%0b want=0", in_ready); end
        total++; if (out_instruction !== 32'h0000_0013) begin bad++; $display("FAIL async_instr got=%h want=00000013", out_instruction); end
        @(posedge clock);
        #1 reset = 1'b1;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL async_release_in_ready got=%0b want=1", in_ready); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL async_release_count got=%0d want=0", count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_wrap();
        test_back_to_back();
        test_flush();
        test_illegal_async();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
